// File: rtl/sdio_cmd_pkg.sv
// Shared constants, state encoding and received-frame layout for the SDIO CMD responder.
package sdio_cmd_pkg;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_R1   = 2'd1;
  localparam logic [1:0] RSP_R2   = 2'd2;
  localparam logic [1:0] RSP_R3   = 2'd3;

  localparam int unsigned CMD_LEN = 48;
  localparam int unsigned R2_LEN  = 136;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT_RSP,
    TX
  } state_t;

  // Host command as captured after the start bit (47 bits, MSB first).
  typedef struct packed {
    logic        trans;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        end_bit;
  } rx_frame_t;

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled clk.
module sdio_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_crc <= 7'd0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sdio_cmd_responder.sv
// Card-side SDIO CMD engine: receives 48-bit host commands, hands {idx,arg} to the
// card logic and serialises its R1/R2/R3 response after the NCR gap.
module sdio_cmd_responder
  import sdio_cmd_pkg::*;
#(
  parameter int unsigned NCR       = 2,
  parameter int unsigned LGTIMEOUT = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sd_ck,
  input  logic         i_cmd,
  output logic         o_cmd,
  output logic         o_cmd_oe,
  output logic         o_cmd_valid,
  output logic [5:0]   o_cmd_idx,
  output logic [31:0]  o_cmd_arg,
  output logic [1:0]   o_cmd_err,
  input  logic         i_rsp_valid,
  output logic         o_rsp_ready,
  input  logic [1:0]   i_rsp_type,
  input  logic [5:0]   i_rsp_idx,
  input  logic [126:0] i_rsp_data,
  output logic         o_busy,
  output logic         o_rsp_timeout
);

  localparam int unsigned GAP_W = LGTIMEOUT + 1;
  localparam int unsigned TMO   = 1 << LGTIMEOUT;
  localparam logic [7:0]  LEN48 = 8'(CMD_LEN);
  localparam logic [7:0]  LEN136 = 8'(R2_LEN);

  logic r_ck_meta, r_ck_q1, r_ck_q2;
  logic r_cmd_meta, r_cmd_q;
  logic w_rise, w_fall;

  state_t             r_state;
  rx_frame_t          r_rx_sr;
  logic [5:0]         r_bitcnt;
  logic [GAP_W-1:0]   r_gapcnt;
  logic               r_accepted;
  logic [135:0]       r_tx_sr;
  logic [7:0]         r_tx_len;
  logic [7:0]         r_txcnt;
  logic               r_tx_crc_ins;

  logic        r_cmd, r_cmd_oe, r_cmd_valid, r_rsp_ready, r_busy, r_rsp_timeout;
  logic [5:0]  r_cmd_idx;
  logic [31:0] r_cmd_arg;
  logic [1:0]  r_cmd_err;

  logic [6:0] w_rx_crc, w_tx_crc;
  logic       w_rx_crc_en, w_tx_crc_en, w_tx_crc_clr, w_rx_crc_clr;
  logic [1:0] w_rx_err;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ck_meta  <= 1'b0;
      r_ck_q1    <= 1'b0;
      r_ck_q2    <= 1'b0;
      r_cmd_meta <= 1'b1;
      r_cmd_q    <= 1'b1;
    end else begin
      r_ck_meta  <= i_sd_ck;
      r_ck_q1    <= r_ck_meta;
      r_ck_q2    <= r_ck_q1;
      r_cmd_meta <= i_cmd;
      r_cmd_q    <= r_cmd_meta;
    end
  end

  assign w_rise = r_ck_q1 & ~r_ck_q2;
  assign w_fall = ~r_ck_q1 & r_ck_q2;

  // RX CRC covers the start bit through the argument; the start bit is 0 so it is implicit.
  assign w_rx_crc_clr = (r_state == IDLE);
  assign w_rx_crc_en  = (r_state == RX) && w_rise && (r_bitcnt < 6'd40);
  assign w_tx_crc_clr = (r_state != TX);
  assign w_tx_crc_en  = (r_state == TX) && w_fall && (r_txcnt < 8'd40);
  assign w_rx_err     = {~r_rx_sr.end_bit, (w_rx_crc != r_rx_sr.crc)};

  sdio_crc7 u_rx_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_rx_crc_clr),
    .i_en  (w_rx_crc_en),
    .i_bit (r_cmd_q),
    .o_crc (w_rx_crc)
  );

  sdio_crc7 u_tx_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tx_crc_clr),
    .i_en  (w_tx_crc_en),
    .i_bit (r_tx_sr[135]),
    .o_crc (w_tx_crc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_rx_sr       <= '0;
      r_bitcnt      <= 6'd0;
      r_gapcnt      <= '0;
      r_accepted    <= 1'b0;
      r_tx_sr       <= '1;
      r_tx_len      <= LEN48;
      r_txcnt       <= 8'd0;
      r_tx_crc_ins  <= 1'b0;
      r_cmd         <= 1'b1;
      r_cmd_oe      <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_idx     <= 6'd0;
      r_cmd_arg     <= 32'd0;
      r_cmd_err     <= 2'b00;
      r_rsp_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_cmd_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise && !r_cmd_q) begin
            r_state  <= RX;
            r_bitcnt <= 6'd1;
            r_busy   <= 1'b1;
          end
        end
        RX: begin
          if (w_rise) begin
            r_rx_sr  <= {r_rx_sr[45:0], r_cmd_q};
            r_bitcnt <= 6'(r_bitcnt + 6'd1);
            if (r_bitcnt == 6'd47) r_state <= CHECK;
          end
        end
        CHECK: begin
          // A cleared transmission bit means another card's response is on the line.
          if (!r_rx_sr.trans) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cmd_valid <= 1'b1;
            r_cmd_idx   <= r_rx_sr.idx;
            r_cmd_arg   <= r_rx_sr.arg;
            r_cmd_err   <= w_rx_err;
            if (w_rx_err != 2'b00) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= WAIT_RSP;
              r_rsp_ready <= 1'b1;
              r_gapcnt    <= '0;
              r_accepted  <= 1'b0;
            end
          end
        end
        WAIT_RSP: begin
          if (r_rsp_ready && i_rsp_valid) begin
            r_rsp_ready <= 1'b0;
            if (i_rsp_type == RSP_NONE) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_accepted <= 1'b1;
              case (i_rsp_type)
                RSP_R1: begin
                  r_tx_sr      <= {2'b00, i_rsp_idx, i_rsp_data[31:0], {96{1'b1}}};
                  r_tx_len     <= LEN48;
                  r_tx_crc_ins <= 1'b1;
                end
                RSP_R3: begin
                  r_tx_sr      <= {2'b00, 6'h3F, i_rsp_data[31:0], {96{1'b1}}};
                  r_tx_len     <= LEN48;
                  r_tx_crc_ins <= 1'b0;
                end
                default: begin
                  r_tx_sr      <= {2'b00, 6'h3F, i_rsp_data, 1'b1};
                  r_tx_len     <= LEN136;
                  r_tx_crc_ins <= 1'b0;
                end
              endcase
            end
          end else if (!r_accepted && (r_gapcnt == GAP_W'(TMO))) begin
            r_rsp_timeout <= 1'b1;
            r_state       <= IDLE;
            r_busy        <= 1'b0;
          end
          // Ready drops on the final rise so a late valid can never race the timeout.
          if (w_rise && (r_gapcnt != GAP_W'(TMO))) begin
            r_gapcnt <= GAP_W'(r_gapcnt + GAP_W'(1));
            if (!r_accepted && (r_gapcnt == GAP_W'(TMO - 1))) r_rsp_ready <= 1'b0;
          end
          if (r_accepted && (r_gapcnt >= GAP_W'(NCR))) begin
            r_state <= TX;
            r_txcnt <= 8'd0;
          end
        end
        TX: begin
          if (w_fall) begin
            if (r_txcnt == r_tx_len) begin
              r_cmd_oe <= 1'b0;
              r_cmd    <= 1'b1;
              r_state  <= IDLE;
              r_busy   <= 1'b0;
            end else begin
              r_cmd_oe <= 1'b1;
              r_txcnt  <= 8'(r_txcnt + 8'd1);
              if (r_tx_crc_ins && (r_txcnt == 8'd40)) begin
                r_cmd   <= w_tx_crc[6];
                r_tx_sr <= {w_tx_crc[5:0], {130{1'b1}}};
              end else begin
                r_cmd   <= r_tx_sr[135];
                r_tx_sr <= {r_tx_sr[134:0], 1'b1};
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd         = r_cmd;
  assign o_cmd_oe      = r_cmd_oe;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_idx     = r_cmd_idx;
  assign o_cmd_arg     = r_cmd_arg;
  assign o_cmd_err     = r_cmd_err;
  assign o_rsp_ready   = r_rsp_ready;
  assign o_busy        = r_busy;
  assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_sdio_cmd_responder.sv
// Self-checking bench: host + client models around sdio_cmd_responder.
module tb_sdio_cmd_responder;
  import sdio_cmd_pkg::*;

  localparam int NCR_TB = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sd_ck = 1'b0;
  logic         host_cmd = 1'b1;
  logic         w_line;
  logic         o_cmd, o_cmd_oe, o_cmd_valid, o_rsp_ready, o_busy, o_rsp_timeout;
  logic [5:0]   o_cmd_idx;
  logic [31:0]  o_cmd_arg;
  logic [1:0]   o_cmd_err;
  logic         i_rsp_valid = 1'b0;
  logic [1:0]   i_rsp_type = 2'd0;
  logic [5:0]   i_rsp_idx = 6'd0;
  logic [126:0] i_rsp_data = '0;

  int n_checks = 0;
  int n_pass = 0;

  // Monitor state
  int           rise_cnt = 0;
  int           end_rise = 0;
  int           tx_start_rise = 0;
  int           to_rise = 0;
  int           n_tx_bits = 0;
  logic [135:0] got_bits = '0;
  bit           got_valid = 0, ready_seen = 0, oe_seen = 0, to_seen = 0;
  logic [5:0]   got_idx;
  logic [31:0]  got_arg;
  logic [1:0]   got_err;

  assign w_line = o_cmd_oe ? o_cmd : host_cmd;

  always #5 clk = ~clk;
  always #40 sd_ck = ~sd_ck;

  sdio_cmd_responder dut (
    .clk           (clk),
    .reset         (reset),
    .i_sd_ck       (sd_ck),
    .i_cmd         (w_line),
    .o_cmd         (o_cmd),
    .o_cmd_oe      (o_cmd_oe),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd_idx     (o_cmd_idx),
    .o_cmd_arg     (o_cmd_arg),
    .o_cmd_err     (o_cmd_err),
    .i_rsp_valid   (i_rsp_valid),
    .o_rsp_ready   (o_rsp_ready),
    .i_rsp_type    (i_rsp_type),
    .i_rsp_idx     (i_rsp_idx),
    .i_rsp_data    (i_rsp_data),
    .o_busy        (o_busy),
    .o_rsp_timeout (o_rsp_timeout)
  );

  // Host side: sample the card's drive on every sd_ck rise.
  always @(posedge sd_ck) begin
    rise_cnt++;
    if (o_cmd_oe) begin
      if (n_tx_bits == 0) tx_start_rise = rise_cnt;
      got_bits = {got_bits[134:0], w_line};
      n_tx_bits++;
    end
  end

  always @(negedge clk) begin
    if (o_cmd_valid) begin
      got_valid = 1;
      got_idx   = o_cmd_idx;
      got_arg   = o_cmd_arg;
      got_err   = o_cmd_err;
    end
    if (o_rsp_ready) ready_seen = 1;
    if (o_cmd_oe) oe_seen = 1;
    if (o_rsp_timeout && !to_seen) begin
      to_seen = 1;
      to_rise = rise_cnt;
    end
  end

  // Reference CRC7 by polynomial long division of msg * x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] msg);
    logic [46:0] v;
    logic [46:0] poly;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) begin
        poly = 47'h89;
        v = v ^ (poly << (i - 7));
      end
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_div(m), 1'b1};
  endfunction

  function automatic logic [135:0] rsp_frame(input logic [1:0] t, input logic [5:0] idx,
                                            input logic [126:0] d);
    logic [39:0] m;
    if (t == RSP_R2) return {2'b00, 6'h3F, d, 1'b1};
    if (t == RSP_R3) return {88'd0, 2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1};
    m = {2'b00, idx, d[31:0]};
    return {88'd0, m, crc7_div(m), 1'b1};
  endfunction

  task automatic clear_mon;
    got_valid = 0; ready_seen = 0; oe_seen = 0; to_seen = 0;
    n_tx_bits = 0; got_bits = '0;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_ck);
      host_cmd = f[i];
    end
    end_rise = rise_cnt + 1;
    @(negedge sd_ck);
    host_cmd = 1'b1;
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 400 && !got_valid; i++) @(negedge clk);
  endtask

  task automatic respond(input logic [1:0] t, input logic [5:0] idx, input logic [126:0] d,
                         input int dly);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (o_rsp_ready) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL rsp_ready: never asserted, required 1");
    end else begin
      repeat (dly) @(negedge clk);
      i_rsp_valid = 1'b1; i_rsp_type = t; i_rsp_idx = idx; i_rsp_data = d;
      @(posedge clk);
      #1 i_rsp_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int i = 0; i < 4000 && !idle; i++) begin
      @(negedge clk);
      if (!o_busy) idle = 1;
    end
    n_checks++;
    if (!idle) $display("FAIL %s idle: o_busy still 1 after bound, required 0", name);
    else n_pass++;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_cmd, o_cmd_oe} !== 2'b10)
      $display("FAIL reset_line: got cmd/oe=%b required 10", {o_cmd, o_cmd_oe});
    else n_pass++;
    n_checks++;
    if ({o_cmd_valid, o_cmd_idx, o_cmd_arg, o_cmd_err, o_rsp_ready, o_busy, o_rsp_timeout} !== '0)
      $display("FAIL reset_outs: got valid=%b idx=%h arg=%h err=%b rdy=%b busy=%b to=%b required all 0",
               o_cmd_valid, o_cmd_idx, o_cmd_arg, o_cmd_err, o_rsp_ready, o_busy, o_rsp_timeout);
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_cmd0;
    clear_mon();
    send_cmd(48'h40_0000_0000_95);
    wait_valid();
    n_checks++;
    if (!got_valid || {got_idx, got_arg, got_err} !== 40'd0)
      $display("FAIL cmd0_decode: got v=%0d idx=%h arg=%h err=%b required v=1 idx=0 arg=0 err=00",
               got_valid, got_idx, got_arg, got_err);
    else n_pass++;
    respond(RSP_NONE, 6'd0, '0, 0);
    wait_idle("cmd0");
    n_checks++;
    if (oe_seen || n_tx_bits != 0)
      $display("FAIL cmd0_no_drive: got oe_seen=%0d bits=%0d required 0/0", oe_seen, n_tx_bits);
    else n_pass++;
  endtask

  task automatic test_cmd8_r1;
    clear_mon();
    send_cmd(48'h48_0000_01AA_87);
    wait_valid();
    n_checks++;
    if (!got_valid || {got_idx, got_arg, got_err} !== {6'd8, 32'h1AA, 2'b00})
      $display("FAIL cmd8_decode: got v=%0d idx=%h arg=%h err=%b required v=1 idx=08 arg=1aa err=00",
               got_valid, got_idx, got_arg, got_err);
    else n_pass++;
    respond(RSP_R1, 6'd8, 127'h1AA, 0);
    wait_idle("cmd8");
    n_checks++;
    if (n_tx_bits != 48 || got_bits[47:0] !== 48'h08_0000_01AA_13)
      $display("FAIL cmd8_rsp: got %0d bits %h required 48 bits 08000001aa13", n_tx_bits, got_bits[47:0]);
    else n_pass++;
    n_checks++;
    if (tx_start_rise - end_rise != NCR_TB + 1)
      $display("FAIL cmd8_gap: got start %0d rises after end bit, required %0d",
               tx_start_rise - end_rise, NCR_TB + 1);
    else n_pass++;
  endtask

  task automatic test_bad_frames;
    logic [47:0] frames [2];
    logic [1:0]  errs [2];
    frames[0] = 48'h48_0000_01AA_89; errs[0] = 2'b01;
    frames[1] = 48'h48_0000_01AA_86; errs[1] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      send_cmd(frames[k]);
      wait_valid();
      n_checks++;
      if (!got_valid || got_err !== errs[k])
        $display("FAIL bad_frame%0d_err: got v=%0d err=%b required v=1 err=%b", k, got_valid, got_err, errs[k]);
      else n_pass++;
      repeat (10) @(negedge sd_ck);
      n_checks++;
      if (ready_seen || oe_seen || o_busy)
        $display("FAIL bad_frame%0d_quiet: got ready=%0d oe=%0d busy=%b required 0", k, ready_seen, oe_seen, o_busy);
      else n_pass++;
    end
  endtask

  task automatic test_other_device;
    logic [39:0] m;
    clear_mon();
    m = {2'b00, 6'd8, 32'h1AA};
    send_cmd({m, crc7_div(m), 1'b1});
    repeat (10) @(negedge sd_ck);
    n_checks++;
    if (got_valid || ready_seen || o_busy)
      $display("FAIL other_device: got valid=%0d ready=%0d busy=%b required 0", got_valid, ready_seen, o_busy);
    else n_pass++;
  endtask

  task automatic test_timeout;
    clear_mon();
    send_cmd(cmd_frame(6'd2, 32'd0));
    wait_valid();
    for (int i = 0; i < 1200 && !to_seen; i++) @(negedge clk);
    n_checks++;
    if (!to_seen || to_rise - end_rise != 64)
      $display("FAIL timeout_time: got seen=%0d after %0d rises required 64", to_seen, to_rise - end_rise);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (oe_seen || o_busy)
      $display("FAIL timeout_quiet: got oe_seen=%0d busy=%b required 0", oe_seen, o_busy);
    else n_pass++;
  endtask

  task automatic test_r2;
    logic [135:0] exp;
    clear_mon();
    send_cmd(cmd_frame(6'd2, 32'd0));
    respond(RSP_R2, 6'd0, 127'h1, 0);
    wait_idle("r2");
    exp = {2'b00, 6'h3F, 127'h1, 1'b1};
    n_checks++;
    if (n_tx_bits != 136 || got_bits !== exp)
      $display("FAIL r2_frame: got %0d bits %h required 136 bits %h", n_tx_bits, got_bits, exp);
    else n_pass++;
    n_checks++;
    if (tx_start_rise - end_rise != NCR_TB + 1)
      $display("FAIL r2_gap: got %0d required %0d", tx_start_rise - end_rise, NCR_TB + 1);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [5:0]   idx, ridx;
    logic [31:0]  arg;
    logic [1:0]   t;
    logic [126:0] d;
    logic [135:0] exp;
    int           len, dly;
    for (int k = 0; k < 8; k++) begin
      idx  = 6'($urandom);
      arg  = $urandom;
      ridx = 6'($urandom);
      t    = 2'($urandom_range(1, 3));
      d    = 127'({$urandom, $urandom, $urandom, $urandom});
      dly  = $urandom_range(0, 30);
      exp  = rsp_frame(t, ridx, d);
      len  = (t == RSP_R2) ? 136 : 48;
      clear_mon();
      send_cmd(cmd_frame(idx, arg));
      wait_valid();
      n_checks++;
      if (!got_valid || {got_idx, got_arg, got_err} !== {idx, arg, 2'b00})
        $display("FAIL rand%0d_decode: got idx=%h arg=%h err=%b required idx=%h arg=%h err=00",
                 k, got_idx, got_arg, got_err, idx, arg);
      else n_pass++;
      respond(t, ridx, d, dly);
      wait_idle("rand");
      n_checks++;
      if (n_tx_bits != len || got_bits !== exp)
        $display("FAIL rand%0d_rsp type %0d: got %0d bits %h required %0d bits %h",
                 k, t, n_tx_bits, got_bits, len, exp);
      else n_pass++;
      n_checks++;
      if (tx_start_rise - end_rise < NCR_TB + 1)
        $display("FAIL rand%0d_gap: got %0d required >= %0d", k, tx_start_rise - end_rise, NCR_TB + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_tx;
    clear_mon();
    send_cmd(cmd_frame(6'd8, 32'h1AA));
    respond(RSP_R1, 6'd8, 127'h1AA, 0);
    for (int i = 0; i < 2000 && n_tx_bits < 20; i++) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({o_cmd_oe, o_cmd, o_busy} !== 3'b010)
      $display("FAIL reset_mid_tx: got oe/cmd/busy=%b required 010", {o_cmd_oe, o_cmd, o_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge sd_ck);
    clear_mon();
    send_cmd(48'h40_0000_0000_95);
    wait_valid();
    n_checks++;
    if (!got_valid || {got_idx, got_arg, got_err} !== 40'd0)
      $display("FAIL post_reset_cmd0: got v=%0d idx=%h arg=%h err=%b required v=1 idx=0 arg=0 err=00",
               got_valid, got_idx, got_arg, got_err);
    else n_pass++;
    respond(RSP_NONE, 6'd0, '0, 0);
    wait_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8_r1();
    test_bad_frames();
    test_other_device();
    test_timeout();
    test_r2();
    test_random();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
